// File: rtl/mux_scan_n.sv
// N-channel, WIDTH-bit multiplexer with a registered output.
// Direct mode selects by S; scan mode steps an internal pointer, dwelling DWELL enabled cycles per channel.
module mux_scan_n #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   I,
  input  logic [SEL_W-1:0]        S,
  input  logic                    mode,
  input  logic                    en,
  output logic [WIDTH-1:0]        Y,
  output logic [SEL_W-1:0]        Y_ch,
  output logic                    valid,
  output logic                    wrap
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);

  typedef enum logic {
    DIRECT = 1'b0,
    SCAN   = 1'b1
  } mode_e;

  logic [WIDTH-1:0] r_y;
  logic [SEL_W-1:0] r_ch;
  logic             r_valid;
  logic             r_wrap;
  logic [SEL_W-1:0] r_ptr;
  logic [DW_W-1:0]  r_dwell;

  logic [WIDTH-1:0] w_selData;
  logic             w_selInRange;
  logic [WIDTH-1:0] w_ptrData;
  logic             w_lastDwell;
  logic             w_lastCh;
  mode_e            w_mode;

  // Loop-based decode keeps out-of-range selects (non power-of-2 N_CH) from indexing past I.
  always_comb begin
    w_selData    = '0;
    w_selInRange = 1'b0;
    w_ptrData    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (S == SEL_W'(k)) begin
        w_selData    = I[k*WIDTH +: WIDTH];
        w_selInRange = 1'b1;
      end
      if (r_ptr == SEL_W'(k)) begin
        w_ptrData = I[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_lastDwell = (r_dwell == LAST_DW);
  assign w_lastCh    = (r_ptr == LAST_CH);
  assign w_mode      = mode_e'(mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_ptr   <= '0;
      r_dwell <= '0;
    end else if (!en) begin
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      case (w_mode)
        DIRECT: begin
          r_y     <= w_selInRange ? w_selData : '0;
          r_ch    <= S;
          r_valid <= w_selInRange;
          r_wrap  <= 1'b0;
          r_ptr   <= '0;
          r_dwell <= '0;
        end
        SCAN: begin
          r_y     <= w_ptrData;
          r_ch    <= r_ptr;
          r_valid <= 1'b1;
          r_wrap  <= w_lastCh && w_lastDwell;
          if (w_lastDwell) begin
            r_dwell <= '0;
            r_ptr   <= w_lastCh ? '0 : r_ptr + SEL_W'(1);
          end else begin
            r_dwell <= r_dwell + DW_W'(1);
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_wrap  <= 1'b0;
        end
      endcase
    end
  end

  assign Y     = r_y;
  assign Y_ch  = r_ch;
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule
